// File: rtl/spiflash_slave.sv
// SPI flash read slave: 0xAB wake-up, 0x03 streaming read, all logic on clk.
// Optional fast read (0x0B + FAST_DUMMY dummy clocks) when SPIFLASH_SLAVE_FASTREAD_EN is defined.
module spiflash_slave #(
    parameter int FAST_DUMMY = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        spi_cs,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [23:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        awake,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DUMMY  = 3'd3,
        DATA   = 3'd4,
        IGNORE = 3'd5
    } state_t;

    state_t      state;
    logic        cs_q;
    logic        sclk_q;
    logic [2:0]  bitcnt;
    logic [4:0]  addrcnt;
    logic [22:0] shreg;
    logic        rise;
    logic        cs_fall;
    logic [7:0]  cmd_byte;
    logic [23:0] addr_next;

    if (FAST_DUMMY < 1 || FAST_DUMMY > 255) begin : g_bad_dummy
        $error("FAST_DUMMY must be in 1..255");
    end

`ifdef SPIFLASH_SLAVE_FASTREAD_EN
    logic       fast;
    logic [7:0] dcnt;
`endif

    assign rise      = spi_sclk & ~sclk_q;
    assign cs_fall   = ~spi_cs & cs_q;
    // Command and address include the bit arriving on the current rise.
    assign cmd_byte  = {shreg[6:0], spi_mosi};
    assign addr_next = {shreg, spi_mosi};

    assign spi_miso = (state == DATA) ? mem_rdata[3'd7 - bitcnt] : 1'b0;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b1;
            bitcnt   <= 3'd0;
            addrcnt  <= 5'd0;
            shreg    <= 23'd0;
            mem_addr <= 24'd0;
            awake    <= 1'b0;
`ifdef SPIFLASH_SLAVE_FASTREAD_EN
            fast     <= 1'b0;
            dcnt     <= 8'd0;
`endif
        end else begin
            cs_q   <= spi_cs;
            sclk_q <= spi_sclk;
            if (spi_cs) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= CMD;
                            bitcnt  <= 3'd0;
                            addrcnt <= 5'd0;
`ifdef SPIFLASH_SLAVE_FASTREAD_EN
                            fast    <= 1'b0;
                            dcnt    <= 8'd0;
`endif
                        end
                    end
                    CMD: begin
                        if (rise) begin
                            shreg  <= addr_next[22:0];
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                state <= IGNORE;
                                if (cmd_byte == 8'hAB) begin
                                    awake <= 1'b1;
                                end else if (cmd_byte == 8'h03 && awake) begin
                                    state <= ADDR;
`ifdef SPIFLASH_SLAVE_FASTREAD_EN
                                end else if (cmd_byte == 8'h0B && awake) begin
                                    state <= ADDR;
                                    fast  <= 1'b1;
`endif
                                end
                            end
                        end
                    end
                    ADDR: begin
                        if (rise) begin
                            shreg   <= addr_next[22:0];
                            addrcnt <= addrcnt + 5'd1;
                            if (addrcnt == 5'd23) begin
                                mem_addr <= addr_next;
                                bitcnt   <= 3'd0;
                                state    <= DATA;
`ifdef SPIFLASH_SLAVE_FASTREAD_EN
                                if (fast) begin
                                    state <= DUMMY;
                                    dcnt  <= 8'd0;
                                end
`endif
                            end
                        end
                    end
`ifdef SPIFLASH_SLAVE_FASTREAD_EN
                    DUMMY: begin
                        if (rise) begin
                            dcnt <= dcnt + 8'd1;
                            if (dcnt == 8'(FAST_DUMMY - 1)) begin
                                state  <= DATA;
                                bitcnt <= 3'd0;
                            end
                        end
                    end
`endif
                    DATA: begin
                        // bitcnt wraps 7 -> 0 on its own as the byte completes.
                        if (rise) begin
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                mem_addr <= mem_addr + 24'd1;
                            end
                        end
                    end
                    IGNORE: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
